// File: rtl/seq_sub64.sv
// Multi-cycle subtractor: d = x - y - bIn, evaluated one SLICE-bit ripple slice per clock
// behind valid/ready handshakes on both the operand and the result side.
module seq_sub64 #(
   parameter int WIDTH = 64,
   parameter int SLICE = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inValid,
   output logic             inReady,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             bIn,
   output logic             outValid,
   input  logic             outReady,
   output logic [WIDTH-1:0] d,
   output logic             bOut,
   output logic             ovf,
   output logic             zero
);
   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_y;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_d;
   logic [CW-1:0]    r_cnt;
   logic             r_x_msb;
   logic             r_y_msb;
   logic             r_borrow;
   logic             r_bout;
   logic             r_ovf;
   logic             r_zero;
   logic             r_out_valid;

   logic [SLICE:0]   w_diff;
   logic [WIDTH-1:0] w_d_next;
   logic             w_ovf;

   // Operands shift right each cycle so the active slice is always the low SLICE bits;
   // bit SLICE of the widened difference is the borrow out of that slice.
   assign w_diff = {1'b0, r_x[SLICE-1:0]} - {1'b0, r_y[SLICE-1:0]} - {{SLICE{1'b0}}, r_borrow};

   generate
      if (N == 1) begin : g_single
         assign w_d_next = w_diff[SLICE-1:0];
      end else begin : g_multi
         assign w_d_next = {w_diff[SLICE-1:0], r_acc[WIDTH-1:SLICE]};
      end
   endgenerate

   assign w_ovf = (r_x_msb != r_y_msb) && (w_d_next[WIDTH-1] != r_x_msb);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_x         <= '0;
         r_y         <= '0;
         r_acc       <= '0;
         r_d         <= '0;
         r_cnt       <= '0;
         r_x_msb     <= 1'b0;
         r_y_msb     <= 1'b0;
         r_borrow    <= 1'b0;
         r_bout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_zero      <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (inValid) begin
                  r_x      <= x;
                  r_y      <= y;
                  r_x_msb  <= x[WIDTH-1];
                  r_y_msb  <= y[WIDTH-1];
                  r_borrow <= bIn;
                  r_cnt    <= '0;
                  r_state  <= RUN;
               end
            end
            RUN: begin
               r_x      <= r_x >> SLICE;
               r_y      <= r_y >> SLICE;
               r_acc    <= w_d_next;
               r_borrow <= w_diff[SLICE];
               r_cnt    <= r_cnt + CW'(1);
               if (r_cnt == LAST) begin
                  r_d         <= w_d_next;
                  r_bout      <= w_diff[SLICE];
                  r_zero      <= (w_d_next == '0);
                  r_ovf       <= w_ovf;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (outReady) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign inReady  = (r_state == IDLE);
   assign outValid = r_out_valid;
   assign d        = r_d;
   assign bOut     = r_bout;
   assign ovf      = r_ovf;
   assign zero     = r_zero;
endmodule
